// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   - state_t      : debounce FSM states
//   - NUM_ROWS/COLS: matrix geometry
//   - KEY_0..KEY_F : key codes (code = 4*row + col) for the calculator legend
//   - result_t     : 5-bit scan result, MSB = valid flag, low nibble = key code
//   - scan_result(): reduces a pressed-bit snapshot to one key or NONE
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef logic [4:0] result_t;
  localparam result_t RESULT_NONE = 5'b0_0000;

  // Bit index of the snapshot equals the key code, so a single pressed bit
  // maps directly to its code. Zero or several pressed bits give NONE.
  function automatic result_t scan_result(input logic [15:0] pressed);
    int         n_pressed;
    logic [3:0] idx;
    n_pressed = 0;
    idx       = 4'd0;
    for (int i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
      if (pressed[i]) begin
        n_pressed++;
        idx = 4'(i);
      end
    end
    return (n_pressed == 1) ? {1'b1, idx} : RESULT_NONE;
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// keypad_scan_timer: column slot timing for the keypad scanner.
//   clk, rst  : clock, asynchronous active-low reset
//   col       : current column index 0..3, advances every SCAN_DIV cycles
//   slot_last : high on the last cycle of each column slot
//   scan_done : high on the last cycle of column 3 (full scan complete)
module keypad_scan_timer #(
  parameter int SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] col,
  output logic       slot_last,
  output logic       scan_done
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] slot_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      col      <= 2'd0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      col      <= col + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign slot_last = (slot_cnt == CW'(SCAN_DIV - 1));
  assign scan_done = slot_last && (col == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce, ghost reject and
// a valid/ack key handshake.
//   clk       : system clock
//   rst       : asynchronous reset, active-low
//   ROWIN     : keypad rows, active-low, asynchronous
//   KEY_ACK   : consumer acknowledge of KEY_CODE
//   COLSEL    : column drive, one-hot active-low
//   KEY_CODE  : accepted key code (4*row + col)
//   KEY_VALID : KEY_CODE holds an unacknowledged key
//   KEY_LOST  : sticky, a key event was dropped while KEY_VALID was high
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat every
// REPEAT_SCANS scans while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ROWIN,
  input  logic       KEY_ACK,
  output logic [3:0] COLSEL,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_LOST
);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1)
  begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  localparam logic [4:0] DS = 5'(DEBOUNCE_SCANS);

  logic [1:0] col;
  logic       slot_last;
  logic       scan_done;

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .slot_last(slot_last),
    .scan_done(scan_done)
  );

  assign COLSEL = ~(4'b0001 << col);

  // Row synchronizer; idle (released) level is all-ones.
  logic [3:0] row_meta, row_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= ROWIN;
      row_sync <= row_meta;
    end
  end

  // Snapshot holds pressed bits (active-high) at index 4*row + col.
  logic [15:0] snapshot;

  // NOTE: the snapshot is a flop array with a reset because a stale pressed
  // bit left over after reset would be evaluated as a real key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot <= '0;
    end else if (slot_last) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        snapshot[r * NUM_COLS + int'(col)] <= ~row_sync[r];
      end
    end
  end

  // Column 3 is captured in the same cycle the scan is evaluated, so the
  // evaluation uses the live rows for that column instead of the stored bits.
  logic [15:0] scan_view;
  result_t     result;

  always_comb begin
    scan_view = snapshot;
    for (int r = 0; r < NUM_ROWS; r++) begin
      scan_view[r * NUM_COLS + NUM_COLS - 1] = ~row_sync[r];
    end
  end

  assign result = scan_result(scan_view);

  // Debounce FSM
  state_t     state, state_next;
  logic [3:0] cand, cand_next;
  logic [3:0] cnt, cnt_next;
  logic [3:0] rcnt, rcnt_next;
  logic       emit;
  logic       match;
  logic [4:0] cnt_inc, rcnt_inc;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_cnt, rep_cnt_next, rep_inc;
  assign rep_inc = rep_cnt + 1'b1;
`endif

  assign match    = (result == {1'b1, cand});
  assign cnt_inc  = {1'b0, cnt} + 5'd1;
  assign rcnt_inc = {1'b0, rcnt} + 5'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= 4'd0;
      rcnt  <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      state <= state_next;
      cand  <= cand_next;
      cnt   <= cnt_next;
      rcnt  <= rcnt_next;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= rep_cnt_next;
`endif
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    rcnt_next  = rcnt;
    emit       = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_next = rep_cnt;
`endif
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (result[4]) begin
            state_next = DEBOUNCE;
            cand_next  = result[3:0];
            cnt_next   = 4'd1;
          end
        end
        DEBOUNCE: begin
          if (match) begin
            if (cnt_inc >= DS) begin
              emit       = 1'b1;
              state_next = PRESSED;
              cnt_next   = 4'd0;
            end else begin
              cnt_next = cnt_inc[3:0];
            end
          end else if (result[4]) begin
            cand_next = result[3:0];
            cnt_next  = 4'd1;
          end else begin
            state_next = IDLE;
            cnt_next   = 4'd0;
          end
        end
        PRESSED: begin
          if (!match) begin
            state_next = RELEASE;
            rcnt_next  = 4'd1;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc == RW'(REPEAT_SCANS)) begin
              emit         = 1'b1;
              rep_cnt_next = '0;
            end else begin
              rep_cnt_next = rep_inc;
            end
`endif
          end
        end
        RELEASE: begin
          if (result == RESULT_NONE) begin
            if (rcnt_inc >= DS) begin
              state_next = IDLE;
              rcnt_next  = 4'd0;
            end else begin
              rcnt_next = rcnt_inc[3:0];
            end
          end else if (match) begin
            state_next = PRESSED;
            rcnt_next  = 4'd0;
          end else begin
            // A different key while the old one may still be bouncing:
            // debounce it from scratch, no emission yet.
            state_next = DEBOUNCE;
            cand_next  = result[3:0];
            cnt_next   = 4'd1;
            rcnt_next  = 4'd0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_next == PRESSED && state != PRESSED) begin
      rep_cnt_next = '0;
    end
`endif
  end

  // Key handshake: an emission wins over a plain acknowledge; an emission
  // accompanied by KEY_ACK replaces the consumed code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      KEY_CODE  <= 4'd0;
      KEY_VALID <= 1'b0;
      KEY_LOST  <= 1'b0;
    end else if (emit) begin
      if (!KEY_VALID || KEY_ACK) begin
        KEY_CODE  <= cand;
        KEY_VALID <= 1'b1;
      end else begin
        KEY_LOST <= 1'b1;
      end
    end else if (KEY_VALID && KEY_ACK) begin
      KEY_VALID <= 1'b0;
      KEY_LOST  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with
// SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=8. A behavioural keypad model
// pulls a row low when a held key sits in the driven column.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD   = 4;
  localparam int DSC  = 3;
  localparam int RS   = 8;
  localparam int SCAN = 4 * SD;
  localparam int LAT  = (DSC + 1) * SCAN + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rowin;
  logic        key_ack = 1'b0;
  logic [3:0]  colsel;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_lost;
  logic [15:0] keys = '0;

  int n_cmp = 0;
  int n_bad = 0;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DSC),
    .REPEAT_SCANS  (RS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ROWIN    (rowin),
    .KEY_ACK  (key_ack),
    .COLSEL   (colsel),
    .KEY_CODE (key_code),
    .KEY_VALID(key_valid),
    .KEY_LOST (key_lost)
  );

  always #5 clk = ~clk;

  always_comb begin
    rowin = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r * 4 + c] && !colsel[c]) rowin[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that starts column 0 of a new scan.
  task automatic align();
    int guard;
    guard = 0;
    while (colsel !== 4'b0111 && guard < 200) begin cycles(1); guard++; end
    while (colsel !== 4'b1110 && guard < 200) begin cycles(1); guard++; end
    if (guard >= 200) check("align_timeout", 32'd1, 32'd0);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    cycles(1);
    key_ack = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!key_valid && n < limit) begin cycles(1); n++; end
  endtask

  typedef struct {
    string       name;
    logic [15:0] mask;
    logic        exp_valid;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{"key0",       16'h0001, 1'b1, KEY_0};
    vecs[1] = '{"key6",       16'h0040, 1'b1, KEY_6};
    vecs[2] = '{"keyF",       16'h8000, 1'b1, KEY_F};
    vecs[3] = '{"keyC",       16'h1000, 1'b1, KEY_C};
    vecs[4] = '{"ghost_row",  16'h0006, 1'b0, KEY_0};
    vecs[5] = '{"ghost_col",  16'h0011, 1'b0, KEY_0};

    // Reset state
    cycles(3);
    check("rst_colsel", colsel, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_lost", key_lost, 1'b0);
    check("rst_code", key_code, 4'd0);
    rst = 1'b1;
    cycles(2);

    // Clean press of row 2 / col 1 held 20 scans
    keys = 16'h0200;
    wait_valid(LAT, n);
    check("t1_latency", (key_valid && n <= LAT), 1'b1);
    check("t1_code", key_code, KEY_9);
    ack_pulse();
    check("t1_ack_clears", key_valid, 1'b0);
    cycles(18 * SCAN);
`ifndef KEYPAD_REPEAT_EN
    check("t1_single_emission", key_valid, 1'b0);
`endif
    keys = '0;
    cycles(6 * SCAN);
    ack_pulse();

    // Table of single presses and ghosts
    for (int i = 0; i < 6; i++) begin
      keys = vecs[i].mask;
      cycles(6 * SCAN);
      check({vecs[i].name, "_valid"}, key_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check({vecs[i].name, "_code"}, key_code, vecs[i].exp_code);
      check({vecs[i].name, "_lost"}, key_lost, 1'b0);
      ack_pulse();
      check({vecs[i].name, "_after_ack"}, key_valid, 1'b0);
      keys = '0;
      cycles(6 * SCAN);
    end

    // Bouncing press of row 0 / col 3
    align();
    keys = 16'h0008;
    cycles(SCAN);
    keys = '0;
    cycles(SCAN);
    keys = 16'h0008;
    cycles(2 * SCAN);
    check("bounce_no_early", key_valid, 1'b0);
    cycles(SCAN);
    check("bounce_valid", key_valid, 1'b1);
    check("bounce_code", key_code, KEY_3);
    ack_pulse();
    keys = '0;
    cycles(6 * SCAN);

    // Ghost pair in row 1, then release col 2
    keys = 16'h0050;
    cycles(6 * SCAN);
    check("ghost_pair_valid", key_valid, 1'b0);
    align();
    keys = 16'h0010;
    cycles(2 * SCAN);
    check("ghost_release_early", key_valid, 1'b0);
    cycles(SCAN);
    check("ghost_release_valid", key_valid, 1'b1);
    check("ghost_release_code", key_code, KEY_4);
    ack_pulse();
    keys = '0;
    cycles(6 * SCAN);

    // Two presses without acknowledge
    keys = 16'h0020;
    cycles(6 * SCAN);
    keys = '0;
    cycles(6 * SCAN);
    keys = 16'h0400;
    cycles(6 * SCAN);
    keys = '0;
    cycles(6 * SCAN);
    check("lost_code", key_code, KEY_5);
    check("lost_valid", key_valid, 1'b1);
    check("lost_flag", key_lost, 1'b1);
    ack_pulse();
    check("lost_ack_valid", key_valid, 1'b0);
    check("lost_ack_flag", key_lost, 1'b0);

    // Reset mid-debounce
    keys = 16'h0080;
    align();
    cycles(SCAN + 5);
    rst = 1'b0;
    #1;
    check("rst_mid_colsel", colsel, 4'b1110);
    check("rst_mid_valid", key_valid, 1'b0);
    check("rst_mid_lost", key_lost, 1'b0);
    cycles(2);
    rst = 1'b1;
    cycles(2 * SCAN);
    check("rst_redebounce_early", key_valid, 1'b0);
    wait_valid(LAT, n);
    check("rst_redebounce_valid", key_valid, 1'b1);
    check("rst_redebounce_code", key_code, KEY_7);

    // Reset while VALID is high
    cycles(3);
    rst = 1'b0;
    #1;
    check("rst_valid_colsel", colsel, 4'b1110);
    check("rst_valid_valid", key_valid, 1'b0);
    check("rst_valid_code", key_code, 4'd0);
    check("rst_valid_lost", key_lost, 1'b0);
    keys = '0;
    cycles(2);
    rst = 1'b1;
    cycles(6 * SCAN);
    check("rst_after_idle", key_valid, 1'b0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: key 15 held 30 scans with immediate acknowledges
    align();
    keys = 16'h8000;
    for (int s = 1; s <= 30; s++) begin
      logic exp_v;
      key_ack = key_valid;
      cycles(1);
      key_ack = 1'b0;
      cycles(SCAN - 1);
      exp_v = (s == 3) || (s > 3 && ((s - 3) % RS) == 0);
      check($sformatf("repeat_scan%0d", s), key_valid, exp_v);
      if (exp_v) check($sformatf("repeat_code%0d", s), key_code, KEY_F);
    end
    ack_pulse();
    keys = '0;
    cycles(6 * SCAN);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side companion to the display multiplexer for the calculator datapath. The block drives a 4x4 matrix keypad one column at a time, samples the rows, debounces, rejects multi-key ghosts and delivers one 4-bit key code per press over a valid/ack handshake to the calculator FSM. Column drive is active-low and one-hot, matching the display select convention.

## Interface
- SCAN_DIV, 16: clock cycles each column is driven. Minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press or a release. Range 1..15.
- REPEAT_SCANS, 32: full scans between auto-repeat emissions. Used only with the `KEYPAD_REPEAT_EN` macro.
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- ROWIN  input  4  keypad rows, active-low, externally pulled up, asynchronous.
- KEY_ACK  input  1  consumer acknowledges KEY_CODE. Sampled on the clk rising edge.
- COLSEL  output  4  column drive, one-hot active-low.
- KEY_CODE  output  4  code of the accepted key = 4*row + col.
- KEY_VALID  output  1  KEY_CODE holds an unacknowledged key.
- KEY_LOST  output  1  sticky flag: a key event was dropped because KEY_VALID was already high.

## Operation
- ROWIN passes through a 2-flop synchronizer, reset to 4'b1111.
- Column index col (0..3) advances every SCAN_DIV cycles and wraps 3->0. COLSEL = ~(1<<col).
- The synchronized rows are captured into snapshot bits [4*r+col] on the last cycle of each column slot. The slot is SCAN_DIV cycles long, which leaves the 2-cycle synchronizer time to settle.
- A scan completes on the last cycle of column 3. The snapshot is then evaluated:
  - zero pressed bits gives NONE;
  - exactly one pressed bit gives that key;
  - two or more pressed bits gives NONE (ghost reject).
- The FSM evaluates only at scan completion:
  - **IDLE**: result is a key -> go to DEBOUNCE, cand=key, cnt=1. Otherwise stay.
  - **DEBOUNCE**:
    - result == cand: cnt++. When cnt reaches DEBOUNCE_SCANS, emit cand and go to PRESSED.
    - result differs (including NONE): go to IDLE, or restart DEBOUNCE with the new key, cnt=1.
    - DEBOUNCE_SCANS=1 emits on the first matching scan.
  - **PRESSED**: any result != cand -> go to RELEASE, rcnt=1. Otherwise stay.
  - **RELEASE**:
    - result == NONE: rcnt++. When rcnt reaches DEBOUNCE_SCANS, go to IDLE.
    - result == cand: go back to PRESSED.
    - result is another single key: go to DEBOUNCE with that key, cnt=1. No emission while the old key is still bouncing.
- Emission behaviour:
  - KEY_VALID low, or KEY_ACK high in the same cycle: KEY_CODE <= code, KEY_VALID <= 1.
  - Otherwise: the event is dropped, KEY_CODE is unchanged and KEY_LOST <= 1.
- Handshake:
  - KEY_VALID high with KEY_ACK high and no emission: KEY_VALID <= 0 and KEY_LOST <= 0.
  - KEY_ACK while KEY_VALID is low is ignored.

## Timing
- Reset values:
  - COLSEL = 4'b1110;
  - KEY_CODE = 0;
  - KEY_VALID = 0;
  - KEY_LOST = 0;
  - FSM in IDLE, col = 0, counters = 0, snapshot = all released.
- Reset is asynchronous and may arrive mid-scan or mid-handshake. All state returns to the values above. A pending key is discarded.
- Scan period is 4*SCAN_DIV cycles.
- KEY_VALID rises one cycle after the scan-completion cycle that satisfies the debounce condition.
- Press-to-valid latency for a clean press is at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- KEY_VALID falls one cycle after the KEY_ACK cycle.
- A key held forever produces exactly one emission (macro off).
- COLSEL changes only at slot boundaries and is never all-ones after reset.

## Configuration
- Macro: `KEYPAD_REPEAT_EN`.
  - Defined: in PRESSED, a repeat counter increments on each scan that still returns cand. At REPEAT_SCANS it emits cand again (same emission/KEY_LOST rules) and resets to 0. The counter clears on entry to PRESSED.
  - Undefined: no repeat counter exists, and REPEAT_SCANS is unused.

## Structure
- Shared package `keypad_pkg`:
  - state enum {IDLE, DEBOUNCE, PRESSED, RELEASE};
  - NUM_ROWS = 4 and NUM_COLS = 4;
  - key code constants KEY_0..KEY_F for the calculator legend;
  - the NONE encoding of the scan result, 5 bits with MSB as the valid flag.
- One sub-module, `keypad_scan_timer`: slot counter, column index and scan-complete strobe.
- The snapshot, FSM and handshake stay in keypad_scanner.

## Test plan
Bench parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Clean press of row 2/col 1, held 20 scans -> KEY_CODE=9, KEY_VALID high within 67 cycles. After ACK, no further VALID (macro off).
- Press row 0/col 3 that bounces (released for 1 of the first 3 scans) -> no emission until 3 consecutive matches, then KEY_CODE=3.
- Row 1/col 0 and row 1/col 2 held simultaneously -> no KEY_VALID. Release col 2 -> KEY_CODE=4 after 3 scans.
- Two sequential presses (5 then 10) with KEY_ACK held low -> KEY_CODE=5, KEY_LOST=1. ACK clears both VALID and LOST.
- rst asserted mid-DEBOUNCE and while VALID is high -> outputs immediately return to COLSEL=1110, VALID=0, LOST=0. A held key is re-debounced after release of rst.
- Macro defined, REPEAT_SCANS=8, key 15 held 30 scans with immediate ACKs -> emissions at scan 3 and then every 8 scans after.
